// File: rtl/miriscv_timer.sv
// Memory-mapped prescaled compare timer with sticky MATCH flag and level interrupt request.
// Optional wrap interrupt (STATUS.OVF / CTRL.OVF_IE) enabled by defining MIRISCV_TIMER_OVF_IRQ_EN.
module miriscv_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
  parameter int unsigned PRESC_W   = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        int_req_o,
  input  logic        int_fin_i
);

`ifdef MIRISCV_TIMER_OVF_IRQ_EN
  localparam bit HAS_OVF = 1'b1;
`else
  localparam bit HAS_OVF = 1'b0;
`endif
  localparam logic [3:0] CTRL_MASK = {HAS_OVF, 3'b111};

  localparam logic [2:0] IDX_CTRL   = 3'd0;
  localparam logic [2:0] IDX_PRESC  = 3'd1;
  localparam logic [2:0] IDX_CNT    = 3'd2;
  localparam logic [2:0] IDX_CMP    = 3'd3;
  localparam logic [2:0] IDX_STATUS = 3'd4;

  typedef enum logic {S_IDLE, S_PEND} state_e;

  logic [3:0]         ctrl_q, ctrl_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [31:0]        cmp_q, cmp_d;
  logic               match_q, match_d;
  logic               ovf_q, ovf_d;
  state_e             state_q;
  logic               int_req_q;

  logic        sel, rd, wr_any;
  logic [2:0]  idx;
  logic        tick, hit, ovf_set;
  logic        clr_match, clr_ovf, fin_clr;
  logic [31:0] presc_merged;
  logic        addr_unused;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int unsigned b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  assign addr_unused = ^data_addr_i[1:0];
  assign sel    = data_req_i && (data_addr_i[31:5] == BASE_ADDR[31:5]);
  assign idx    = data_addr_i[4:2];
  assign rd     = sel && !data_we_i;
  assign wr_any = sel && data_we_i && (data_be_i != 4'b0000);

  assign tick    = ctrl_q[0] && (pcnt_q == presc_q);
  assign hit     = tick && (cnt_q == cmp_q);
  assign ovf_set = HAS_OVF && tick && !hit && (cnt_q == '1);

  assign clr_match = wr_any && idx == IDX_STATUS && data_be_i[0] && data_wdata_i[0];
  assign clr_ovf   = HAS_OVF && wr_any && idx == IDX_STATUS && data_be_i[0] && data_wdata_i[1];
  assign fin_clr   = (state_q == S_PEND) && int_fin_i;

  assign presc_merged = be_merge(32'(presc_q), data_wdata_i, data_be_i);

  always_comb begin
    ctrl_d  = ctrl_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    cmp_d   = cmp_q;
    pcnt_d  = pcnt_q + 1'b1;

    if (!ctrl_q[0] || tick) pcnt_d = '0;

    if (tick) cnt_d = hit ? '0 : cnt_q + 32'd1;
    if (hit && !ctrl_q[1]) ctrl_d[0] = 1'b0;

    // Bus writes are applied last so they win over the counter's own updates.
    if (wr_any) begin
      unique case (idx)
        IDX_CTRL:  if (data_be_i[0]) ctrl_d = data_wdata_i[3:0] & CTRL_MASK;
        IDX_PRESC: begin
          presc_d = presc_merged[PRESC_W-1:0];
          pcnt_d  = '0;
        end
        IDX_CNT:   cnt_d = be_merge(cnt_q, data_wdata_i, data_be_i);
        IDX_CMP:   cmp_d = be_merge(cmp_q, data_wdata_i, data_be_i);
        default: ;
      endcase
    end

    match_d = hit | (match_q & ~(clr_match | fin_clr));
    ovf_d   = ovf_set | (ovf_q & ~(clr_ovf | fin_clr));
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ctrl_q  <= '0;
      presc_q <= '0;
      pcnt_q  <= '0;
      cnt_q   <= '0;
      cmp_q   <= '1;
      match_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      int_req_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if ((match_q && ctrl_q[2]) || (ovf_q && ctrl_q[3])) begin
          state_q   <= S_PEND;
          int_req_q <= 1'b1;
        end
        S_PEND: if (int_fin_i || clr_match || clr_ovf) begin
          state_q   <= S_IDLE;
          int_req_q <= 1'b0;
        end
        default: begin
          state_q   <= S_IDLE;
          int_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign int_req_o = int_req_q;

  always_comb begin
    data_rdata_o = '0;
    if (rd && rst_n_i) begin
      unique case (idx)
        IDX_CTRL:   data_rdata_o = {28'd0, ctrl_q};
        IDX_PRESC:  data_rdata_o = 32'(presc_q);
        IDX_CNT:    data_rdata_o = cnt_q;
        IDX_CMP:    data_rdata_o = cmp_q;
        IDX_STATUS: data_rdata_o = {30'd0, ovf_q, match_q};
        default:    data_rdata_o = '0;
      endcase
    end
  end

endmodule
